// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and helpers for the RV32I memory stage
package pipe_pkg;

  localparam logic [1:0] ALU_SRC = 2'b00;
  localparam logic [1:0] MEM_SRC = 2'b01;
  localparam logic [1:0] PC_SRC  = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // funct3[1:0] carries the access size for both signed and unsigned forms
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   is_aligned = (off[0] == 1'b0);
      2'b10:   is_aligned = (off == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wd);
    case (funct3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/halfword of a read word and extends it
module load_align
  import pipe_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rdata[7:0];
    case (addr)
      2'b00: byteSel = rdata[7:0];
      2'b01: byteSel = rdata[15:8];
      2'b10: byteSel = rdata[23:16];
      2'b11: byteSel = rdata[31:24];
      default: byteSel = rdata[7:0];
    endcase
  end

  assign halfSel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byteSel[7]}}, byteSel};
      F3_BU:   data = {24'b0, byteSel};
      F3_H:    data = {{16{halfSel[15]}}, halfSel};
      F3_HU:   data = {16'b0, halfSel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// rtl/stage_memory.sv - RV32I memory stage: stage register, data-memory handshake, load alignment
module stage_memory
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  regSrcE,
  input  logic        regWriteE,
  input  logic        memReadE,
  input  logic        memWriteE,
  input  logic [2:0]  funct3E,
  input  logic [4:0]  rdAddrE,
  input  logic [31:0] aluResultE,
  input  logic [31:0] writeDataE,
  input  logic [31:0] pcPlus4E,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [3:0]  dmemBe,
  input  logic [31:0] dmemRdata,
  input  logic        dmemAck,
  output logic        stallM,
  output logic [1:0]  regSrcM,
  output logic        regWriteM,
  output logic [4:0]  rdAddrM,
  output logic [31:0] aluResultM,
  output logic [31:0] readDataM,
  output logic [31:0] pcPlus4M,
  output logic        misalignM,
  output logic        busErrM
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]  regSrcR;
  logic        regWriteR;
  logic        memReadR;
  logic        memWriteR;
  logic [2:0]  funct3R;
  logic [4:0]  rdAddrR;
  logic [31:0] aluResultR;
  logic [31:0] writeDataR;
  logic [31:0] pcPlus4R;

  mem_state_t       state;
  logic [CNT_W-1:0] waitCnt;

  logic        memOp;
  logic        aligned;
  logic        active;
  logic        misalign;
  logic        timeout;
  logic [31:0] loadData;

  // Stage register: a stalled instruction stays put until its access resolves
  always_ff @(posedge clk) begin
    if (rst) begin
      regSrcR    <= ALU_SRC;
      regWriteR  <= 1'b0;
      memReadR   <= 1'b0;
      memWriteR  <= 1'b0;
      funct3R    <= 3'b000;
      rdAddrR    <= 5'd0;
      aluResultR <= 32'd0;
      writeDataR <= 32'd0;
      pcPlus4R   <= 32'd0;
    end else if (!stallM) begin
      regSrcR    <= regSrcE;
      regWriteR  <= regWriteE;
      memReadR   <= memReadE;
      memWriteR  <= memWriteE;
      funct3R    <= funct3E;
      rdAddrR    <= rdAddrE;
      aluResultR <= aluResultE;
      writeDataR <= writeDataE;
      pcPlus4R   <= pcPlus4E;
    end
  end

  assign memOp    = memReadR | memWriteR;
  assign aligned  = is_aligned(funct3R, aluResultR[1:0]);
  assign active   = memOp & aligned;
  assign misalign = memOp & ~aligned;
  assign timeout  = (state == MEM_WAIT) & (waitCnt == CNT_LAST) & ~dmemAck;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MEM_IDLE;
      waitCnt <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (active && !dmemAck) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmemAck || timeout || !active) begin
            state   <= MEM_IDLE;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: begin
          state   <= MEM_IDLE;
          waitCnt <= '0;
        end
      endcase
    end
  end

  assign dmemReq   = active;
  assign dmemWe    = memWriteR;
  assign dmemAddr  = {aluResultR[31:2], 2'b00};
  assign dmemWdata = store_data(funct3R, writeDataR);
  assign dmemBe    = !active   ? 4'b0000 :
                     memWriteR ? store_be(funct3R, aluResultR[1:0]) : 4'b1111;

  assign stallM = active & ~dmemAck & ~timeout;

  load_align u_load_align (
    .addr   (aluResultR[1:0]),
    .funct3 (funct3R),
    .rdata  (dmemRdata),
    .data   (loadData)
  );

  // Writeback only sees a register write once the instruction has really completed
  assign regSrcM    = regSrcR;
  assign regWriteM  = regWriteR & ~stallM & ~misalign & ~timeout;
  assign rdAddrM    = rdAddrR;
  assign aluResultM = aluResultR;
  assign pcPlus4M   = pcPlus4R;
  assign readDataM  = (memReadR && active && dmemAck) ? loadData : 32'd0;
  assign misalignM  = misalign;
  assign busErrM    = timeout;

endmodule

// File: tb/tb_stage_memory.sv
// tb/tb_stage_memory.sv - directed self-checking bench for stage_memory
module tb_stage_memory;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  regSrcE;
  logic        regWriteE;
  logic        memReadE;
  logic        memWriteE;
  logic [2:0]  funct3E;
  logic [4:0]  rdAddrE;
  logic [31:0] aluResultE;
  logic [31:0] writeDataE;
  logic [31:0] pcPlus4E;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemBe;
  logic [31:0] dmemRdata;
  logic        dmemAck;
  logic        stallM;
  logic [1:0]  regSrcM;
  logic        regWriteM;
  logic [4:0]  rdAddrM;
  logic [31:0] aluResultM;
  logic [31:0] readDataM;
  logic [31:0] pcPlus4M;
  logic        misalignM;
  logic        busErrM;

  int checks = 0;
  int errors = 0;

  stage_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .regSrcE(regSrcE), .regWriteE(regWriteE), .memReadE(memReadE), .memWriteE(memWriteE),
    .funct3E(funct3E), .rdAddrE(rdAddrE), .aluResultE(aluResultE), .writeDataE(writeDataE),
    .pcPlus4E(pcPlus4E),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemBe(dmemBe), .dmemRdata(dmemRdata), .dmemAck(dmemAck),
    .stallM(stallM), .regSrcM(regSrcM), .regWriteM(regWriteM), .rdAddrM(rdAddrM),
    .aluResultM(aluResultM), .readDataM(readDataM), .pcPlus4M(pcPlus4M),
    .misalignM(misalignM), .busErrM(busErrM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_e(input logic [1:0] src, input logic we, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [4:0] rdA, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc);
    regSrcE = src; regWriteE = we; memReadE = rd; memWriteE = wr; funct3E = f3;
    rdAddrE = rdA; aluResultE = alu; writeDataE = wd; pcPlus4E = pc;
  endtask

  task automatic bubble();
    set_e(ALU_SRC, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Advance one edge; inputs change 1ns after it, checks follow 2ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dmemAck = 1'b0;
    dmemRdata = 32'd0;
    set_e(MEM_SRC, 1'b1, 1'b1, 1'b0, F3_W, 5'd3, 32'h0000_0104, 32'h1111_1111, 32'h0000_0044);

    // Reset clears the stage even with a load presented upstream
    tick(); #2;
    chk("rst_req",   32'(dmemReq), 32'd0);
    chk("rst_we",    32'(dmemWe), 32'd0);
    chk("rst_be",    32'(dmemBe), 32'd0);
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_rw",    32'(regWriteM), 32'd0);
    chk("rst_mis",   32'(misalignM), 32'd0);
    chk("rst_berr",  32'(busErrM), 32'd0);
    chk("rst_addr",  dmemAddr, 32'd0);
    chk("rst_wdata", dmemWdata, 32'd0);
    chk("rst_rdata", readDataM, 32'd0);
    chk("rst_alu",   aluResultM, 32'd0);
    chk("rst_pc",    pcPlus4M, 32'd0);

    // LW 0x100, zero-wait
    rst = 1'b0;
    set_e(MEM_SRC, 1'b1, 1'b1, 1'b0, F3_W, 5'd5, 32'h0000_0100, 32'h0, 32'h0000_0008);
    tick();
    dmemAck = 1'b1; dmemRdata = 32'hDEAD_BEEF;
    set_e(MEM_SRC, 1'b1, 1'b1, 1'b0, F3_B, 5'd6, 32'h0000_0103, 32'h0, 32'h0000_000C);
    #2;
    chk("lw_req",   32'(dmemReq), 32'd1);
    chk("lw_we",    32'(dmemWe), 32'd0);
    chk("lw_addr",  dmemAddr, 32'h0000_0100);
    chk("lw_be",    32'(dmemBe), 32'hF);
    chk("lw_stall", 32'(stallM), 32'd0);
    chk("lw_data",  readDataM, 32'hDEAD_BEEF);
    chk("lw_rw",    32'(regWriteM), 32'd1);
    chk("lw_rd",    32'(rdAddrM), 32'd5);
    chk("lw_src",   32'(regSrcM), 32'(MEM_SRC));
    chk("lw_pc",    pcPlus4M, 32'h0000_0008);

    // LB / LBU at 0x103 back to back
    tick();
    dmemRdata = 32'h80FF_FFFF;
    set_e(MEM_SRC, 1'b1, 1'b1, 1'b0, F3_BU, 5'd7, 32'h0000_0103, 32'h0, 32'h0000_0010);
    #2;
    chk("lb_data",  readDataM, 32'hFFFF_FF80);
    chk("lb_stall", 32'(stallM), 32'd0);
    chk("lb_addr",  dmemAddr, 32'h0000_0100);
    tick();
    set_e(ALU_SRC, 1'b0, 1'b0, 1'b1, F3_H, 5'd0, 32'h0000_0102, 32'hABCD_1234, 32'h0000_0014);
    #2;
    chk("lbu_data", readDataM, 32'h0000_0080);
    chk("lbu_rd",   32'(rdAddrM), 32'd7);

    // SH 0x1234 at 0x102, ack on the fourth cycle
    tick();
    dmemAck = 1'b0;
    set_e(ALU_SRC, 1'b1, 1'b0, 1'b0, F3_W, 5'd8, 32'h0000_0055, 32'h0, 32'h0000_0018);
    #2;
    chk("sh_stall1", 32'(stallM), 32'd1);
    chk("sh_be",     32'(dmemBe), 32'hC);
    chk("sh_wdata",  dmemWdata, 32'h1234_1234);
    chk("sh_we",     32'(dmemWe), 32'd1);
    chk("sh_addr",   dmemAddr, 32'h0000_0100);
    chk("sh_req",    32'(dmemReq), 32'd1);
    tick(); #2;
    chk("sh_stall2", 32'(stallM), 32'd1);
    chk("sh_hold",   aluResultM, 32'h0000_0102);
    tick(); #2;
    chk("sh_stall3", 32'(stallM), 32'd1);
    tick();
    dmemAck = 1'b1;
    #2;
    chk("sh_ackstall", 32'(stallM), 32'd0);
    chk("sh_ackreq",   32'(dmemReq), 32'd1);

    // The held ALU op advances; a non-load reads back zero even with ack high
    tick();
    set_e(MEM_SRC, 1'b1, 1'b1, 1'b0, F3_W, 5'd9, 32'h0000_0101, 32'h0, 32'h0000_001C);
    #2;
    chk("alu_res",   aluResultM, 32'h0000_0055);
    chk("alu_rw",    32'(regWriteM), 32'd1);
    chk("alu_req",   32'(dmemReq), 32'd0);
    chk("alu_stall", 32'(stallM), 32'd0);
    chk("alu_rdata", readDataM, 32'd0);
    chk("alu_src",   32'(regSrcM), 32'(ALU_SRC));

    // Misaligned LW at 0x101
    tick();
    dmemAck = 1'b0;
    set_e(MEM_SRC, 1'b1, 1'b1, 1'b0, F3_W, 5'd10, 32'h0000_0200, 32'h0, 32'h0000_0020);
    #2;
    chk("mis_req",   32'(dmemReq), 32'd0);
    chk("mis_pulse", 32'(misalignM), 32'd1);
    chk("mis_rw",    32'(regWriteM), 32'd0);
    chk("mis_stall", 32'(stallM), 32'd0);

    // LW 0x200 never acknowledged: four stall cycles then a bus-error pulse
    tick();
    set_e(ALU_SRC, 1'b1, 1'b0, 1'b0, F3_W, 5'd11, 32'h0000_0077, 32'h0, 32'h0000_0024);
    #2;
    chk("to_mis_clr", 32'(misalignM), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin tick(); #2; end
      chk($sformatf("to_stall%0d", i), 32'(stallM), 32'd1);
      chk($sformatf("to_rw%0d", i), 32'(regWriteM), 32'd0);
      chk($sformatf("to_berr%0d", i), 32'(busErrM), 32'd0);
    end
    tick(); #2;
    chk("to_berr",  32'(busErrM), 32'd1);
    chk("to_stall", 32'(stallM), 32'd0);
    chk("to_rw",    32'(regWriteM), 32'd0);
    tick();
    set_e(MEM_SRC, 1'b1, 1'b1, 1'b0, F3_W, 5'd12, 32'h0000_0300, 32'h0, 32'h0000_0028);
    #2;
    chk("to_resume", aluResultM, 32'h0000_0077);
    chk("to_rw_ok",  32'(regWriteM), 32'd1);
    chk("to_berr0",  32'(busErrM), 32'd0);
    chk("to_req0",   32'(dmemReq), 32'd0);

    // Reset while waiting on LW 0x300; the late ack is ignored
    tick(); #2;
    chk("rw_stall1", 32'(stallM), 32'd1);
    tick();
    rst = 1'b1;
    #2;
    chk("rw_stall2", 32'(stallM), 32'd1);
    tick();
    dmemAck = 1'b1; dmemRdata = 32'hCAFE_F00D;
    #2;
    chk("rr_req",   32'(dmemReq), 32'd0);
    chk("rr_stall", 32'(stallM), 32'd0);
    chk("rr_rw",    32'(regWriteM), 32'd0);
    chk("rr_berr",  32'(busErrM), 32'd0);
    chk("rr_rdata", readDataM, 32'd0);
    chk("rr_addr",  dmemAddr, 32'd0);
    chk("rr_alu",   aluResultM, 32'd0);
    rst = 1'b0;
    bubble();
    tick(); #2;
    chk("rr_req2",   32'(dmemReq), 32'd0);
    chk("rr_rdata2", readDataM, 32'd0);
    chk("rr_berr2",  32'(busErrM), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
